cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller.sv | 157 +++++++++++++++
 tb/tb_cpu_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - accumulator CPU control FSM with memory wait timeout and retired-instruction count
module cpu_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op_code,
  input  logic       mem_ready,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       data_on_dbus,
  output logic       dbus_on_data,
  output logic       alu_on_dbus,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass,
  output logic       add,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       bus_err,
  output logic [7:0] instr_count
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    INIT, FETCH, DECODE, EX_LDA, EX_STA, EX_ADD, EX_JMP, HALT
  } state_t;

  state_t        state, next_state;
  logic [WW-1:0] wait_cnt;
  logic          mem_state;
  logic          mem_wait;
  logic          timed_out;
  logic          retire;

  assign mem_state = (state == FETCH) || (state == EX_LDA) || (state == EX_STA);
  assign mem_wait  = mem_state && !mem_ready;
  assign timed_out = mem_wait && (wait_cnt == TIMEOUT_W);
  assign retire    = (state == EX_LDA || state == EX_STA || state == EX_ADD || state == EX_JMP)
                     && (next_state == FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // The counter restarts whenever the state changes, so every access starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != next_state) begin
      wait_cnt <= '0;
    end else if (mem_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 8'd0;
      bus_err     <= 1'b0;
    end else begin
      if (retire) begin
        instr_count <= instr_count + 8'd1;
      end
      if (next_state == HALT && state != HALT) begin
        bus_err <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:   next_state = FETCH;
      FETCH: begin
        if (mem_ready)      next_state = DECODE;
        else if (timed_out) next_state = HALT;
      end
      DECODE: begin
        case (op_code)
          2'b00:   next_state = EX_LDA;
          2'b01:   next_state = EX_STA;
          2'b10:   next_state = EX_ADD;
          default: next_state = EX_JMP;
        endcase
      end
      EX_LDA, EX_STA: begin
        if (mem_ready)      next_state = FETCH;
        else if (timed_out) next_state = HALT;
      end
      EX_ADD: next_state = FETCH;
      EX_JMP: next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = INIT;
    endcase
  end

  // Outputs are gated by reset so an access in flight drops the instant reset rises.
  always_comb begin
    ir_on_adr    = 1'b0;
    pc_on_adr    = 1'b0;
    data_on_dbus = 1'b0;
    dbus_on_data = 1'b0;
    alu_on_dbus  = 1'b0;
    ld_ir        = 1'b0;
    ld_ac        = 1'b0;
    ld_pc        = 1'b0;
    inc_pc       = 1'b0;
    clr_pc       = 1'b0;
    pass         = 1'b0;
    add          = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    if (!reset) begin
      case (state)
        INIT: clr_pc = 1'b1;
        FETCH: begin
          pc_on_adr    = 1'b1;
          mem_rd       = 1'b1;
          data_on_dbus = 1'b1;
          ld_ir        = mem_ready;
        end
        DECODE: inc_pc = 1'b1;
        EX_LDA: begin
          ir_on_adr    = 1'b1;
          mem_rd       = 1'b1;
          data_on_dbus = 1'b1;
          ld_ac        = mem_ready;
        end
        EX_STA: begin
          ir_on_adr    = 1'b1;
          pass         = 1'b1;
          alu_on_dbus  = 1'b1;
          dbus_on_data = 1'b1;
          mem_wr       = 1'b1;
        end
        EX_ADD: begin
          add          = 1'b1;
          alu_on_dbus  = 1'b1;
          ld_ac        = 1'b1;
        end
        EX_JMP: ld_pc = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - vector table, directed corners and randomized run against a cycle reference model
module tb_cpu_controller;

  localparam int TO = 15;

  localparam logic [14:0] B_IR   = 15'h4000;
  localparam logic [14:0] B_PC   = 15'h2000;
  localparam logic [14:0] B_DOD  = 15'h1000;
  localparam logic [14:0] B_DBD  = 15'h0800;
  localparam logic [14:0] B_ALU  = 15'h0400;
  localparam logic [14:0] B_LDIR = 15'h0200;
  localparam logic [14:0] B_LDAC = 15'h0100;
  localparam logic [14:0] B_LDPC = 15'h0080;
  localparam logic [14:0] B_INC  = 15'h0040;
  localparam logic [14:0] B_CLR  = 15'h0020;
  localparam logic [14:0] B_PASS = 15'h0010;
  localparam logic [14:0] B_ADD  = 15'h0008;
  localparam logic [14:0] B_RD   = 15'h0004;
  localparam logic [14:0] B_WR   = 15'h0002;
  localparam logic [14:0] B_ERR  = 15'h0001;

  localparam logic [14:0] C_FETCH = B_PC | B_RD | B_DOD;
  localparam logic [14:0] C_STA   = B_IR | B_PASS | B_ALU | B_DBD | B_WR;
  localparam logic [14:0] C_LDA   = B_IR | B_RD | B_DOD;

  localparam int P_INIT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op_code;
  logic       mem_ready;
  logic ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus;
  logic ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, mem_rd, mem_wr, bus_err;
  logic [7:0] instr_count;

  int vectors = 0;
  int miscompares = 0;
  int ldpc_seen = 0;

  int m_phase;
  int m_op;
  int m_waits;
  int m_count;

  cpu_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .mem_ready(mem_ready),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .data_on_dbus(data_on_dbus),
    .dbus_on_data(dbus_on_data), .alu_on_dbus(alu_on_dbus), .ld_ir(ld_ir),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc), .pass(pass),
    .add(add), .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        rdy;
    logic [14:0] ctrl;
    logic [7:0]  cnt;
  } vec_t;

  function automatic logic [14:0] dut_ctrl();
    return {ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus, ld_ir, ld_ac,
            ld_pc, inc_pc, clr_pc, pass, add, mem_rd, mem_wr, bus_err};
  endfunction

  function automatic logic [14:0] model_ctrl(input logic rdy);
    case (m_phase)
      P_INIT:   return B_CLR;
      P_FETCH:  return C_FETCH | (rdy ? B_LDIR : 15'h0);
      P_DECODE: return B_INC;
      P_EXEC: begin
        case (m_op)
          0:       return C_LDA | (rdy ? B_LDAC : 15'h0);
          1:       return C_STA;
          2:       return B_ADD | B_ALU | B_LDAC;
          default: return B_LDPC;
        endcase
      end
      default:  return B_ERR;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // A memory phase either finishes, keeps waiting, or gives up after TO waits.
  task automatic model_mem(input logic rdy, input int done_phase, input logic retire);
    if (rdy) begin
      m_phase = done_phase;
      m_waits = 0;
      if (retire) m_count = (m_count + 1) % 256;
    end else if (m_waits == TO) begin
      m_phase = P_HALT;
    end else begin
      m_waits++;
    end
  endtask

  task automatic model_advance(input logic [1:0] op, input logic rdy);
    case (m_phase)
      P_INIT:   begin m_phase = P_FETCH; m_waits = 0; end
      P_FETCH:  model_mem(rdy, P_DECODE, 1'b0);
      P_DECODE: begin m_op = int'(op); m_phase = P_EXEC; m_waits = 0; end
      P_EXEC: begin
        if (m_op >= 2) begin
          m_count = (m_count + 1) % 256;
          m_phase = P_FETCH;
        end else begin
          model_mem(rdy, P_FETCH, 1'b1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input logic [1:0] op, input logic rdy, input bit use_tab,
                       input logic [14:0] tctrl, input logic [7:0] tcnt);
    op_code   = op;
    mem_ready = rdy;
    @(negedge clk);
    if (use_tab) begin
      cmp("table_ctrl", 32'(dut_ctrl()), 32'(tctrl));
      cmp("table_count", 32'(instr_count), 32'(tcnt));
    end else begin
      cmp("model_ctrl", 32'(dut_ctrl()), 32'(model_ctrl(rdy)));
      cmp("model_count", 32'(instr_count), 32'(m_count));
    end
    if (ld_pc) ldpc_seen++;
    model_advance(op, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] op, input logic rdy);
    cycle(op, rdy, 1'b0, 15'h0, 8'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    cmp("reset_ctrl", 32'(dut_ctrl()), 32'h0);
    cmp("reset_count", 32'(instr_count), 32'h0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_phase = P_INIT;
    m_waits = 0;
    m_count = 0;
    m_op    = 0;
  endtask

  vec_t tab[$];
  int   halt_at;

  initial begin
    reset     = 1'b1;
    op_code   = 2'b00;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // ADD, STA with 3 waits, LDA with 1 wait, JMP
    tab.push_back('{2'd2, 1'b1, B_CLR,                 8'd0});
    tab.push_back('{2'd2, 1'b1, C_FETCH | B_LDIR,      8'd0});
    tab.push_back('{2'd2, 1'b1, B_INC,                 8'd0});
    tab.push_back('{2'd2, 1'b1, B_ADD | B_ALU | B_LDAC, 8'd0});
    tab.push_back('{2'd1, 1'b1, C_FETCH | B_LDIR,      8'd1});
    tab.push_back('{2'd1, 1'b0, B_INC,                 8'd1});
    tab.push_back('{2'd1, 1'b0, C_STA,                 8'd1});
    tab.push_back('{2'd1, 1'b0, C_STA,                 8'd1});
    tab.push_back('{2'd1, 1'b0, C_STA,                 8'd1});
    tab.push_back('{2'd1, 1'b1, C_STA,                 8'd1});
    tab.push_back('{2'd0, 1'b1, C_FETCH | B_LDIR,      8'd2});
    tab.push_back('{2'd0, 1'b1, B_INC,                 8'd2});
    tab.push_back('{2'd0, 1'b0, C_LDA,                 8'd2});
    tab.push_back('{2'd0, 1'b1, C_LDA | B_LDAC,        8'd2});
    tab.push_back('{2'd3, 1'b1, C_FETCH | B_LDIR,      8'd3});
    tab.push_back('{2'd3, 1'b1, B_INC,                 8'd3});
    tab.push_back('{2'd3, 1'b1, B_LDPC,                8'd3});
    tab.push_back('{2'd3, 1'b0, C_FETCH,               8'd4});

    do_reset();
    foreach (tab[i]) cycle(tab[i].op, tab[i].rdy, 1'b1, tab[i].ctrl, tab[i].cnt);

    // Timeout in FETCH: HALT must arrive TO+1 edges after FETCH entry and stick.
    do_reset();
    step(2'd0, 1'b1);
    halt_at = 0;
    for (int k = 1; k <= 40 && halt_at == 0; k++) begin
      step(2'd0, 1'b0);
      if (bus_err) halt_at = k;
    end
    cmp("timeout_edges", 32'(halt_at), 32'(TO + 1));
    for (int k = 0; k < 6; k++) step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Ready arriving on the last allowed wait completes cleanly.
    do_reset();
    step(2'd1, 1'b1);
    for (int k = 0; k < TO; k++) step(2'd1, 1'b0);
    step(2'd1, 1'b1);
    cmp("boundary_no_err", 32'(bus_err), 32'h0);
    step(2'd1, 1'b1);
    for (int k = 0; k < TO; k++) step(2'd1, 1'b0);
    step(2'd1, 1'b1);
    cmp("boundary_sta_count", 32'(instr_count), 32'd1);
    cmp("boundary_sta_no_err", 32'(bus_err), 32'h0);

    // 256 jumps wrap the count with one ld_pc each.
    do_reset();
    step(2'd3, 1'b1);
    ldpc_seen = 0;
    for (int i = 0; i < 256; i++) begin
      step(2'd3, 1'b1);
      step(2'd3, 1'b1);
      step(2'd3, 1'b1);
    end
    cmp("jmp_wrap_count", 32'(instr_count), 32'd0);
    cmp("jmp_ldpc_pulses", 32'(ldpc_seen), 32'd256);

    // Reset arriving in the middle of a stalled LDA read.
    step(2'd2, 1'b1);
    step(2'd2, 1'b1);
    step(2'd2, 1'b1);
    step(2'd0, 1'b1);
    step(2'd0, 1'b1);
    mem_ready = 1'b0;
    #2;
    cmp("lda_rd_before_reset", 32'(mem_rd), 32'h1);
    cmp("lda_count_before_reset", 32'(instr_count), 32'd1);
    reset = 1'b1;
    #1;
    cmp("async_rd_drop", 32'(mem_rd), 32'h0);
    cmp("async_wr_drop", 32'(mem_wr), 32'h0);
    cmp("async_count_clear", 32'(instr_count), 32'h0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_phase = P_INIT;
    m_waits = 0;
    m_count = 0;
    step(2'd0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if (m_phase == P_HALT || $urandom_range(0, 299) == 0) do_reset();
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
